demux_dispatch: RTL and testbench
=================================

// Module: demux_dispatch
// PURPOSE
//  Registered, flow-controlled 1-to-LANES dispatcher; sequential successor to the combinational demux.
//  Accepts one word per cycle on a valid/ready input and routes it to one of LANES buffered outputs.
//  Target lane comes from in_sel (explicit mode) or an internal round-robin pointer (rr_mode=1).
//  Sits between a serial producer and per-lane consumers; each lane back-pressures independently.
// PARAMETERS
//  WIDTH   1   data bits per word
//  LANES   4   number of output lanes (2..16)
//  SEL_W   2   select width, = clog2(LANES)
// PORTS
//  clk        in   1            rising-edge clock; single clock domain
//  rst        in   1            synchronous, active-high reset
//  in_data    in   WIDTH        input word
//  in_sel     in   SEL_W        target lane, explicit mode; sel=k -> lane k (k=0 is lane a)
//  rr_mode    in   1            1 = round-robin routing, in_sel ignored
//  in_valid   in   1            input word present
//  in_ready   out  1            dispatcher can take the word this cycle
//  out_data   out  LANES*WIDTH  lane k data at [k*WIDTH +: WIDTH]
//  out_valid  out  LANES        lane k holds a word
//  out_ready  in   LANES        lane k consumer takes the word this cycle
//  rr_ptr     out  SEL_W        current round-robin target
//  drop_pulse out  1            1-cycle pulse: word discarded (sel >= LANES)
//  drop_cnt   out  8            saturating count of discarded words
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): out_valid=0, out_data=0, rr_ptr=0, drop_pulse=0, drop_cnt=0.
//    Reset mid-operation discards all buffered words; in_ready is 0 during the reset cycle.
//  - tgt = rr_mode ? rr_ptr : in_sel.
//  - Each lane: one-entry buffer, states EMPTY / FULL.
//    EMPTY -> FULL on write; FULL -> EMPTY on out_ready with no write; FULL + write + out_ready -> FULL with new data.
//    FULL with no write and no out_ready: hold; out_data stable while out_valid=1 and out_ready=0.
//  - in_ready = !rst & (tgt >= LANES | !out_valid[tgt] | out_ready[tgt]); combinational, never depends on in_valid.
//  - Accept = in_valid & in_ready. Latency: word accepted at edge N appears on out_valid/out_data after edge N, i.e. 1 cycle.
//  - Only the target lane is written; the other lanes are unaffected and drain independently.
//  - rr_ptr advances only on an accept in rr_mode: LANES-1 wraps to 0. With no accept, or with rr_mode=0, it holds.
//    Toggling rr_mode does not reset rr_ptr.
//  - Explicit mode with in_sel >= LANES (only when LANES < 2**SEL_W): in_ready=1. The word is accepted and dropped.
//    drop_pulse=1 for the next cycle; drop_cnt increments and saturates at 255. No lane changes.
//  - Round-robin stalls on a full, undrained target lane; it does not skip to the next lane.
//    This preserves strict word order across lanes.
//  - No combinational path from in_data to out_data.
// STRUCTURE
//  - Package demux_pkg: LANES_DEF=4, SEL_W_DEF=2, typedef enum {LANE_EMPTY, LANE_FULL} lane_st_t, DROP_CNT_W=8.
//  - Sub-module demux_lane_buf: one-entry buffer (clk, rst, wr, wdata, rd_ready, valid, data, can_write).
//    Instantiated LANES times via generate.
//  - Top level holds tgt decode, in_ready mux, rr_ptr counter and drop logic.
// TESTING
//  1. Reset: with rst=1 for 2 cycles -> out_valid=0, rr_ptr=0, drop_cnt=0, in_ready=0.
//     After release, with all lanes empty -> in_ready=1.
//  2. Explicit routing: out_ready=4'b1111; send data=1 with sel=0,1,2,3 on consecutive cycles.
//     -> out_valid one-hot 0001,0010,0100,1000 each 1 cycle later, data=1 on that lane.
//  3. Back-pressure: out_ready[2]=0; send sel=2 twice -> first accepted, lane2 FULL.
//     Second: in_ready=0 and lane2 data held. Then raise out_ready[2] -> second accepted the same cycle.
//  4. Round-robin: rr_mode=1, out_ready all 1, 6 words -> lanes 0,1,2,3,0,1 in order; rr_ptr ends at 2.
//     With lane1 held not-ready at the 2nd word -> stall, rr_ptr stays 1, no skip.
//  5. Drop: LANES=3, SEL_W=2; sel=3 x300 -> in_ready=1 each cycle, drop_pulse each cycle, drop_cnt=255, lanes untouched.
//  6. Simultaneous and mid-reset: lane0 FULL with out_ready[0]=1 and a new word to lane0 -> lane0 stays valid with the new data.
//     Then rst=1 for 1 cycle while lanes are FULL -> all out_valid=0 and rr_ptr=0 next cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and defaults for the demux_dispatch block.
// Lane buffer state encoding and drop-counter width live here.
package demux_pkg;

   localparam int LANES_DEF  = 4;
   localparam int SEL_W_DEF  = 2;
   localparam int DROP_CNT_W = 8;

   typedef enum logic {
      LANE_EMPTY,
      LANE_FULL
   } lane_st_t;

endpackage

// File: rtl/demux_lane_buf.sv
// One-entry output buffer for a single dispatcher lane.
// A write while the consumer takes the current word replaces it in the same cycle.
module demux_lane_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             can_write
);

   lane_st_t         st_q, st_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      // NOTE: defaults first so every path assigns st_d/data_d and no latch is inferred.
      st_d   = st_q;
      data_d = data_q;
      if (wr) begin
         st_d   = LANE_FULL;
         data_d = wdata;
      end else if (st_q == LANE_FULL && rd_ready) begin
         st_d = LANE_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the data register is reset as well, because out_data must read 0 after reset.
      if (rst) begin
         st_q   <= LANE_EMPTY;
         data_q <= '0;
      end else begin
         st_q   <= st_d;
         data_q <= data_d;
      end
   end

   assign valid     = (st_q == LANE_FULL);
   assign data      = data_q;
   assign can_write = (st_q == LANE_EMPTY) || rd_ready;

endmodule

// File: rtl/demux_dispatch.sv
// Registered, flow-controlled 1-to-LANES dispatcher with explicit or round-robin routing.
// Words aimed at a non-existent lane are accepted, discarded and counted.
module demux_dispatch
   import demux_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int LANES = LANES_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  rr_mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]      out_valid,
   input  logic [LANES-1:0]      out_ready,
   output logic [SEL_W-1:0]      rr_ptr,
   output logic                  drop_pulse,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   logic [SEL_W-1:0]      tgt;
   logic                  sel_oob;
   logic                  tgt_can_write;
   logic                  accept;
   logic                  drop;
   logic [LANES-1:0]      lane_wr;
   logic [LANES-1:0]      lane_can_write;

   logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  drop_pulse_q, drop_pulse_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   assign tgt     = rr_mode ? rr_ptr_q : in_sel;
   assign sel_oob = 32'(tgt) >= 32'(LANES);

   always_comb begin
      tgt_can_write = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         if (tgt == SEL_W'(k)) tgt_can_write = lane_can_write[k];
      end
   end

   // Ready never looks at in_valid, so a producer may wait for ready before asserting valid.
   assign in_ready = !rst && (sel_oob || tgt_can_write);
   assign accept   = in_valid && in_ready;
   assign drop     = accept && sel_oob;

   always_comb begin
      lane_wr = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_wr[k] = accept && (tgt == SEL_W'(k));
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      demux_lane_buf #(.WIDTH(WIDTH)) u_buf (
         .clk       (clk),
         .rst       (rst),
         .wr        (lane_wr[g]),
         .wdata     (in_data),
         .rd_ready  (out_ready[g]),
         .valid     (out_valid[g]),
         .data      (out_data[g*WIDTH +: WIDTH]),
         .can_write (lane_can_write[g])
      );
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      drop_pulse_d = drop;
      drop_cnt_d   = drop_cnt_q;
      // The pointer stalls on a blocked lane instead of skipping, keeping word order strict.
      if (accept && rr_mode) begin
         rr_ptr_d = (rr_ptr_q == SEL_W'(LANES - 1)) ? '0 : rr_ptr_q + 1'b1;
      end
      if (drop && drop_cnt_q != '1) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         drop_pulse_q <= drop_pulse_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign rr_ptr     = rr_ptr_q;
   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_demux_dispatch.sv
// Bench for demux_dispatch: a 4-lane instance driven from a vector table with a
// data scoreboard, and a 3-lane instance exercising discard of out-of-range selects.
module tb_demux_dispatch;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 4-lane instance
   logic [3:0]  in_data;
   logic [1:0]  in_sel;
   logic        rr_mode, in_valid, in_ready;
   logic [15:0] out_data;
   logic [3:0]  out_valid, out_ready;
   logic [1:0]  rr_ptr;
   logic        drop_pulse;
   logic [7:0]  drop_cnt;

   // 3-lane instance
   logic [3:0]  in3_data;
   logic [1:0]  in3_sel;
   logic        rr3_mode, in3_valid, in3_ready;
   logic [11:0] out3_data;
   logic [2:0]  out3_valid, out3_ready;
   logic [1:0]  rr3_ptr;
   logic        drop3_pulse;
   logic [7:0]  drop3_cnt;

   demux_dispatch #(.WIDTH(4), .LANES(4), .SEL_W(2)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .rr_mode(rr_mode),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .rr_ptr(rr_ptr), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   demux_dispatch #(.WIDTH(4), .LANES(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst), .in_data(in3_data), .in_sel(in3_sel), .rr_mode(rr3_mode),
      .in_valid(in3_valid), .in_ready(in3_ready), .out_data(out3_data), .out_valid(out3_valid),
      .out_ready(out3_ready), .rr_ptr(rr3_ptr), .drop_pulse(drop3_pulse), .drop_cnt(drop3_cnt)
   );

   typedef struct {
      logic       rr;
      logic [1:0] sel;
      logic       vld;
      logic [3:0] ordy;
      logic [3:0] data;
      int         lane;     // lane the word should land in if accepted
      logic       exp_rdy;  // in_ready during the cycle
      logic [3:0] exp_ov;   // out_valid after the edge
      logic [1:0] exp_ptr;  // rr_ptr after the edge
   } vec_t;

   typedef struct {
      int         lane;
      logic [3:0] data;
   } sb_t;

   sb_t        sb_q[$];
   logic [3:0] last_word [4];
   vec_t       vecs [26];
   int         total = 0;
   int         bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] lane_data(input int k);
      return out_data[k*4 +: 4];
   endfunction

   task automatic apply(input int idx, input vec_t v);
      sb_t e;
      rr_mode   = v.rr;
      in_sel    = v.sel;
      in_valid  = v.vld;
      out_ready = v.ordy;
      in_data   = v.data;
      #1;
      check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_rdy));
      if (v.vld && v.exp_rdy) sb_q.push_back('{lane: v.lane, data: v.data});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_ov));
      check($sformatf("v%0d rr_ptr", idx), 32'(rr_ptr), 32'(v.exp_ptr));
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check($sformatf("v%0d sb valid lane%0d", idx, e.lane), 32'(out_valid[e.lane]), 32'd1);
         check($sformatf("v%0d sb data lane%0d", idx, e.lane), 32'(lane_data(e.lane)), 32'(e.data));
         last_word[e.lane] = e.data;
      end
      for (int k = 0; k < 4; k++) begin
         if (v.exp_ov[k]) check($sformatf("v%0d hold lane%0d", idx, k), 32'(lane_data(k)), 32'(last_word[k]));
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0, 2'd0, 1'b1, 4'b1111, 4'h1, 0, 1'b1, 4'b0001, 2'd0};
      vecs[1]  = '{1'b0, 2'd1, 1'b1, 4'b1111, 4'h2, 1, 1'b1, 4'b0010, 2'd0};
      vecs[2]  = '{1'b0, 2'd2, 1'b1, 4'b1111, 4'h3, 2, 1'b1, 4'b0100, 2'd0};
      vecs[3]  = '{1'b0, 2'd3, 1'b1, 4'b1111, 4'h4, 3, 1'b1, 4'b1000, 2'd0};
      vecs[4]  = '{1'b0, 2'd0, 1'b0, 4'b1111, 4'h0, 0, 1'b1, 4'b0000, 2'd0};
      vecs[5]  = '{1'b0, 2'd2, 1'b1, 4'b1011, 4'h5, 2, 1'b1, 4'b0100, 2'd0};
      vecs[6]  = '{1'b0, 2'd2, 1'b1, 4'b1011, 4'h6, 2, 1'b0, 4'b0100, 2'd0};
      vecs[7]  = '{1'b0, 2'd2, 1'b1, 4'b1111, 4'h6, 2, 1'b1, 4'b0100, 2'd0};
      vecs[8]  = '{1'b0, 2'd0, 1'b0, 4'b1111, 4'h0, 0, 1'b1, 4'b0000, 2'd0};
      vecs[9]  = '{1'b1, 2'd3, 1'b1, 4'b1111, 4'h7, 0, 1'b1, 4'b0001, 2'd1};
      vecs[10] = '{1'b1, 2'd3, 1'b1, 4'b1111, 4'h8, 1, 1'b1, 4'b0010, 2'd2};
      vecs[11] = '{1'b1, 2'd0, 1'b1, 4'b1111, 4'h9, 2, 1'b1, 4'b0100, 2'd3};
      vecs[12] = '{1'b1, 2'd0, 1'b1, 4'b1111, 4'hA, 3, 1'b1, 4'b1000, 2'd0};
      vecs[13] = '{1'b1, 2'd0, 1'b1, 4'b1111, 4'hB, 0, 1'b1, 4'b0001, 2'd1};
      vecs[14] = '{1'b1, 2'd0, 1'b1, 4'b1111, 4'hC, 1, 1'b1, 4'b0010, 2'd2};
      vecs[15] = '{1'b1, 2'd0, 1'b1, 4'b1101, 4'hD, 2, 1'b1, 4'b0110, 2'd3};
      vecs[16] = '{1'b1, 2'd0, 1'b1, 4'b1101, 4'hE, 3, 1'b1, 4'b1010, 2'd0};
      vecs[17] = '{1'b1, 2'd0, 1'b1, 4'b1101, 4'hF, 0, 1'b1, 4'b0011, 2'd1};
      vecs[18] = '{1'b1, 2'd0, 1'b1, 4'b1101, 4'h2, 1, 1'b0, 4'b0010, 2'd1};
      vecs[19] = '{1'b1, 2'd0, 1'b1, 4'b1101, 4'h2, 1, 1'b0, 4'b0010, 2'd1};
      vecs[20] = '{1'b1, 2'd0, 1'b1, 4'b1111, 4'h2, 1, 1'b1, 4'b0010, 2'd2};
      vecs[21] = '{1'b0, 2'd0, 1'b0, 4'b1111, 4'h0, 0, 1'b1, 4'b0000, 2'd2};
      vecs[22] = '{1'b0, 2'd0, 1'b1, 4'b1111, 4'h9, 0, 1'b1, 4'b0001, 2'd2};
      vecs[23] = '{1'b0, 2'd0, 1'b1, 4'b1111, 4'h5, 0, 1'b1, 4'b0001, 2'd2};
      vecs[24] = '{1'b0, 2'd1, 1'b1, 4'b0000, 4'h3, 1, 1'b1, 4'b0011, 2'd2};
      vecs[25] = '{1'b0, 2'd2, 1'b1, 4'b0000, 4'h4, 2, 1'b1, 4'b0111, 2'd2};

      for (int k = 0; k < 4; k++) last_word[k] = 4'h0;

      rst = 1'b1;
      in_data = '0; in_sel = '0; rr_mode = 1'b0; in_valid = 1'b0; out_ready = '0;
      in3_data = '0; in3_sel = '0; rr3_mode = 1'b0; in3_valid = 1'b0; out3_ready = '0;

      // Reset held for two edges
      @(posedge clk);
      #1;
      check("rst1 in_ready", 32'(in_ready), 32'd0);
      check("rst1 in3_ready", 32'(in3_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_data", 32'(out_data), 32'd0);
      check("rst rr_ptr", 32'(rr_ptr), 32'd0);
      check("rst drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst drop_pulse", 32'(drop_pulse), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst out3_valid", 32'(out3_valid), 32'd0);
      check("rst drop3_cnt", 32'(drop3_cnt), 32'd0);
      rst = 1'b0;
      #1;
      check("post-rst in_ready", 32'(in_ready), 32'd1);
      check("post-rst in3_ready", 32'(in3_ready), 32'd1);

      // Explicit routing, back-pressure, round-robin, replace-on-drain
      for (int i = 0; i < 26; i++) apply(i, vecs[i]);

      // Mid-operation reset with lanes 0..2 full; a word offered during reset must not land
      rst = 1'b1; rr_mode = 1'b0; in_sel = 2'd3; in_valid = 1'b1; in_data = 4'h8; out_ready = 4'b0000;
      #1;
      check("midrst in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst rr_ptr", 32'(rr_ptr), 32'd0);
      check("midrst out_data", 32'(out_data), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("after midrst in_ready", 32'(in_ready), 32'd1);
      check("dut4 drop_cnt", 32'(drop_cnt), 32'd0);

      // 3-lane instance: park a word in lane 1, then flood with sel=3
      in3_sel = 2'd1; in3_data = 4'h6; in3_valid = 1'b1; out3_ready = 3'b000;
      #1;
      check("d3 load in_ready", 32'(in3_ready), 32'd1);
      @(posedge clk);
      #1;
      check("d3 load out_valid", 32'(out3_valid), 32'b010);
      check("d3 load data", 32'(out3_data[7:4]), 32'h6);

      in3_sel = 2'd3; in3_valid = 1'b0;
      #1;
      check("d3 oob idle in_ready", 32'(in3_ready), 32'd1);
      @(posedge clk);
      #1;
      check("d3 oob idle pulse", 32'(drop3_pulse), 32'd0);
      check("d3 oob idle cnt", 32'(drop3_cnt), 32'd0);

      for (int i = 0; i < 300; i++) begin
         in3_sel = 2'd3; in3_valid = 1'b1; in3_data = 4'(i);
         #1;
         check($sformatf("d3 drop%0d in_ready", i), 32'(in3_ready), 32'd1);
         @(posedge clk);
         #1;
         check($sformatf("d3 drop%0d pulse", i), 32'(drop3_pulse), 32'd1);
         check($sformatf("d3 drop%0d cnt", i), 32'(drop3_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      end
      in3_valid = 1'b0; in3_sel = 2'd0;
      @(posedge clk);
      #1;
      check("d3 end pulse", 32'(drop3_pulse), 32'd0);
      check("d3 end cnt", 32'(drop3_cnt), 32'd255);
      check("d3 end out_valid", 32'(out3_valid), 32'b010);
      check("d3 end lane1 data", 32'(out3_data[7:4]), 32'h6);
      check("d3 end rr_ptr", 32'(rr3_ptr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
